// File: rtl/exception_unit_pkg.sv
// exception_unit_pkg
// Shared definitions for the MEM-stage exception arbiter:
//   - exception codes reported to cp0_reg through the exception port
//   - CP0 register addresses seen on the WB-stage write port
//   - bit positions of the per-instruction exception flag vector
//   - redirect sequencer state encoding
package exception_unit_pkg;

    // Exception codes (shared with cp0_reg)
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEF = 32'h0000_0010;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_000F;
    localparam logic [31:0] EXC_TR   = 32'h0000_000D;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0011;
    localparam logic [31:0] EXC_ADES = 32'h0000_0012;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // CP0 register addresses (EBase is select 1 of register 15)
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    // Cause bits writable by software: IP[1:0] (9:8), IV (23), WP (22)
    localparam logic [31:0] CAUSE_WB_MASK = 32'h00C0_0300;

    // Bit indices of mem_except_i
    localparam int FLAG_ADEF = 0;
    localparam int FLAG_RI   = 1;
    localparam int FLAG_SYS  = 2;
    localparam int FLAG_BP   = 3;
    localparam int FLAG_TR   = 4;
    localparam int FLAG_OV   = 5;
    localparam int FLAG_ADEL = 6;
    localparam int FLAG_ADES = 7;
    localparam int FLAG_ERET = 8;
    localparam int NUM_FLAGS = 9;

    // Redirect sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } exc_state_e;

endpackage

// File: rtl/exception_unit_priority.sv
// exc_priority
// Purely combinational flag-to-code encoder plus bad-address select.
// Ports:
//   valid_i       MEM holds a real instruction
//   int_pending_i an enabled hardware interrupt is pending
//   flags_i       per-instruction exception flags (see package indices)
//   pc_i          PC of the MEM instruction
//   addr_i        data address of the MEM load/store
//   code_o        selected exception code (0 when none)
//   badvaddr_o    faulting address for address-error codes, else 0
module exc_priority
    import exception_unit_pkg::*;
(
    input  logic                 valid_i,
    input  logic                 int_pending_i,
    input  logic [NUM_FLAGS-1:0] flags_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          addr_i,
    output logic [31:0]          code_o,
    output logic [31:0]          badvaddr_o
);

    // Fixed-priority selection; ERET sits last so a real fault wins over it
    always_comb begin
        code_o = EXC_NONE;
        if (!valid_i) begin
            code_o = EXC_NONE;
        end else if (int_pending_i) begin
            code_o = EXC_INT;
        end else if (flags_i[FLAG_ADEF]) begin
            code_o = EXC_ADEF;
        end else if (flags_i[FLAG_RI]) begin
            code_o = EXC_RI;
        end else if (flags_i[FLAG_SYS]) begin
            code_o = EXC_SYS;
        end else if (flags_i[FLAG_BP]) begin
            code_o = EXC_BP;
        end else if (flags_i[FLAG_TR]) begin
            code_o = EXC_TR;
        end else if (flags_i[FLAG_OV]) begin
            code_o = EXC_OV;
        end else if (flags_i[FLAG_ADEL]) begin
            code_o = EXC_ADEL;
        end else if (flags_i[FLAG_ADES]) begin
            code_o = EXC_ADES;
        end else if (flags_i[FLAG_ERET]) begin
            code_o = EXC_ERET;
        end else begin
            code_o = EXC_NONE;
        end
    end

    // Fetch errors fault on the PC, data errors on the load/store address
    always_comb begin
        badvaddr_o = 32'h0000_0000;
        case (code_o)
            EXC_ADEF:           badvaddr_o = pc_i;
            EXC_ADEL, EXC_ADES: badvaddr_o = addr_i;
            default:            badvaddr_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/exception_unit.sv
// exception_unit
// MEM-stage exception arbiter and pipeline redirect sequencer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_*_i                   MEM-stage instruction info and exception flags
//   cp0_*_i                   current CP0 Status/Cause/EPC/EBase
//   wb_cp0_*_i                WB-stage CP0 write, forwarded over cp0_*_i
//   redirect_ready_i          fetch accepts the redirect this cycle
//   excepttype_o, current_inst_addr_o, is_in_delayslot_o, badvaddr_o
//                             exception port towards cp0_reg
//   flush_o                   flush all pipeline registers
//   redirect_valid_o/new_pc_o redirect handshake towards fetch
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_OFFSET  = 32'h0000_0180,
    parameter int          VECTOR_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [8:0]  mem_except_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_ebase_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic        redirect_ready_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] new_pc_o
);

    // Keeps the top VECTOR_BITS of EBase as the vector page
    localparam logic [31:0] PAGE_MASK = ~(32'hFFFF_FFFF >> VECTOR_BITS);

    exc_state_e  state_q, state_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] status_s, cause_s, epc_s, ebase_s;
    logic        int_pending_s;
    logic [31:0] code_s, badvaddr_s, vector_s;

    // The WB write lands in CP0 only at the next edge, so bypass it here
    assign status_s = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
    assign epc_s    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    ? wb_cp0_data_i : cp0_epc_i;
    assign ebase_s  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EBASE)  ? wb_cp0_data_i : cp0_ebase_i;
    // Only the software-writable Cause fields are taken from WB; the
    // hardware IP bits keep tracking the live interrupt lines
    assign cause_s  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)
                    ? ((cp0_cause_i & ~CAUSE_WB_MASK) | (wb_cp0_data_i & CAUSE_WB_MASK))
                    : cp0_cause_i;

    // IE set, EXL clear, and at least one unmasked pending line
    assign int_pending_s = status_s[0] && !status_s[1] && ((cause_s[15:8] & status_s[15:8]) != 8'h00);

    assign vector_s = (ebase_s & PAGE_MASK) + EXC_OFFSET;

    exc_priority u_priority (
        .valid_i       (mem_valid_i),
        .int_pending_i (int_pending_s),
        .flags_i       (mem_except_i),
        .pc_i          (mem_pc_i),
        .addr_i        (mem_addr_i),
        .code_o        (code_s),
        .badvaddr_o    (badvaddr_s)
    );

    // State and redirect-target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            new_pc_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Next-state logic and exception-port / redirect outputs
    always_comb begin
        state_d             = state_q;
        new_pc_d            = new_pc_q;
        excepttype_o        = EXC_NONE;
        current_inst_addr_o = 32'h0000_0000;
        is_in_delayslot_o   = 1'b0;
        badvaddr_o          = 32'h0000_0000;
        flush_o             = 1'b0;
        redirect_valid_o    = 1'b0;
        new_pc_o            = new_pc_q;
        if (rst) begin
            // Outputs read as zero while reset is held
            state_d  = ST_IDLE;
            new_pc_o = 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    excepttype_o        = code_s;
                    current_inst_addr_o = mem_pc_i;
                    is_in_delayslot_o   = mem_in_delayslot_i;
                    badvaddr_o          = badvaddr_s;
                    flush_o             = (code_s != EXC_NONE);
                    if (code_s != EXC_NONE) begin
                        state_d  = ST_REDIR;
                        new_pc_d = (code_s == EXC_ERET) ? epc_s : vector_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    // MEM is ignored here: the pipeline is being flushed
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    if (redirect_ready_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REDIR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [8:0]  mem_except_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic        redirect_ready_i;
    logic [31:0] excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, redirect_valid_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    exception_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_except_i        (mem_except_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .cp0_ebase_i         (cp0_ebase_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .redirect_ready_i    (redirect_ready_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .badvaddr_o          (badvaddr_o),
        .flush_o             (flush_o),
        .redirect_valid_o    (redirect_valid_o),
        .new_pc_o            (new_pc_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [31:0] cur, input logic [4:0] addr);
        if (wb_cp0_we_i && wb_cp0_waddr_i == addr) return wb_cp0_data_i;
        return cur;
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
            c[9:8]  = wb_cp0_data_i[9:8];
            c[23]   = wb_cp0_data_i[23];
            c[22]   = wb_cp0_data_i[22];
        end
        return c;
    endfunction

    function automatic logic [31:0] m_code();
        logic [31:0] tbl [9] = '{32'h10, 32'hA, 32'h8, 32'hF, 32'hD, 32'hC, 32'h11, 32'h12, 32'hE};
        logic [31:0] st = m_fwd(cp0_status_i, 5'd12);
        logic [31:0] ca = m_cause();
        if (!mem_valid_i) return 32'h0;
        if (st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0)) return 32'h1;
        for (int i = 0; i < 9; i++) if (mem_except_i[i]) return tbl[i];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] code);
        if (code == 32'hE) return m_fwd(cp0_epc_i, 5'd14);
        return (m_fwd(cp0_ebase_i, 5'd15) & 32'hFFFF_F000) + 32'h180;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        mem_valid_i = 1'b0; mem_except_i = 9'h0; mem_pc_i = 32'h0;
        mem_in_delayslot_i = 1'b0; mem_addr_i = 32'h0;
        cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; cp0_ebase_i = 32'h0;
        wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    // Accept the pending redirect and return to IDLE with quiet inputs
    task automatic finish_redirect();
        @(negedge clk);
        clear_inputs();
        redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        redirect_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; clear_inputs(); redirect_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if ({excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o, is_in_delayslot_o, flush_o, redirect_valid_o} !== 131'h0) begin
            tests_failed++;
            $display("FAIL reset_state: exc=%h pc=%h bad=%h npc=%h ds=%b fl=%b rv=%b required all 0",
                     excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o, is_in_delayslot_o, flush_o, redirect_valid_o);
        end
    endtask

    task automatic test_interrupt();
        @(negedge clk);
        cp0_status_i = 32'h0000_FC01; cp0_cause_i = 32'h0000_0400; cp0_ebase_i = 32'h8000_0000;
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_1000;
        #1;
        tests_run++;
        if (excepttype_o !== 32'h1 || flush_o !== 1'b1 || current_inst_addr_o !== 32'h8000_1000) begin
            tests_failed++;
            $display("FAIL irq_detect: exc=%h flush=%b pc=%h required 1/1/80001000", excepttype_o, flush_o, current_inst_addr_o);
        end
        @(posedge clk); #1;
        tests_run++;
        if (redirect_valid_o !== 1'b1 || new_pc_o !== 32'h8000_0180) begin
            tests_failed++;
            $display("FAIL irq_redirect: rv=%b new_pc=%h required 1/80000180", redirect_valid_o, new_pc_o);
        end
        finish_redirect();
    endtask

    task automatic test_delayslot_load();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_except_i = 9'h040; mem_in_delayslot_i = 1'b1;
        mem_addr_i = 32'h8000_0003; mem_pc_i = 32'h8000_0104;
        #1;
        tests_run++;
        if (excepttype_o !== 32'h11 || badvaddr_o !== 32'h8000_0003 || is_in_delayslot_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ds_load: exc=%h bad=%h ds=%b required 11/80000003/1", excepttype_o, badvaddr_o, is_in_delayslot_o);
        end
        finish_redirect();
    endtask

    task automatic test_eret_forward();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_except_i = 9'h100; cp0_epc_i = 32'h0;
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h8000_2000;
        #1;
        tests_run++;
        if (excepttype_o !== 32'hE || badvaddr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL eret_code: exc=%h bad=%h required e/0", excepttype_o, badvaddr_o);
        end
        @(posedge clk); #1;
        tests_run++;
        if (new_pc_o !== 32'h8000_2000 || redirect_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL eret_fwd_pc: new_pc=%h rv=%b required 80002000/1", new_pc_o, redirect_valid_o);
        end
        finish_redirect();
    endtask

    task automatic test_fetch_stall();
        int held = 0;
        @(negedge clk);
        mem_valid_i = 1'b1; mem_except_i = 9'h004; cp0_ebase_i = 32'h9FC0_0000;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (redirect_valid_o === 1'b1 && flush_o === 1'b1) held++;
            tests_run++;
            if (excepttype_o !== 32'h0 || new_pc_o !== 32'h9FC0_0180) begin
                tests_failed++;
                $display("FAIL stall_ignore_mem[%0d]: exc=%h new_pc=%h required 0/9fc00180", i, excepttype_o, new_pc_o);
            end
            if (i == 3) begin redirect_ready_i = 1'b1; clear_inputs(); end
            @(posedge clk); #1;
        end
        redirect_ready_i = 1'b0;
        tests_run++;
        if (held != 4 || redirect_valid_o !== 1'b0 || flush_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_length: held=%0d rv_after=%b flush_after=%b required 4/0/0", held, redirect_valid_o, flush_o);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_except_i = 9'h124;   // eret + ovf + syscall
        #1;
        tests_run++;
        if (excepttype_o !== 32'h8) begin
            tests_failed++; $display("FAIL prio_sys_ovf_eret: exc=%h required 8", excepttype_o);
        end
        cp0_status_i = 32'h0000_FF03; cp0_cause_i = 32'h0000_0400;  // EXL set blocks IRQ
        #1;
        tests_run++;
        if (excepttype_o !== 32'h8) begin
            tests_failed++; $display("FAIL prio_exl_masks_irq: exc=%h required 8", excepttype_o);
        end
        mem_except_i = 9'h180; cp0_status_i = 32'h0;   // eret + store error
        #1;
        tests_run++;
        if (excepttype_o !== 32'h12) begin
            tests_failed++; $display("FAIL prio_eret_vs_ades: exc=%h required 12", excepttype_o);
        end
        mem_valid_i = 1'b0; cp0_status_i = 32'h0000_FF01; mem_except_i = 9'h1FF;
        #1;
        tests_run++;
        if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin
            tests_failed++; $display("FAIL bubble_ignores_irq: exc=%h flush=%b required 0/0", excepttype_o, flush_o);
        end
        clear_inputs();
        @(posedge clk); #1;
        tests_run++;
        if (redirect_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL prio_no_redirect: rv=%b required 0", redirect_valid_o);
        end
    endtask

    task automatic test_reset_in_redir();
        @(negedge clk);
        mem_valid_i = 1'b1; mem_except_i = 9'h008; cp0_ebase_i = 32'h8000_0000;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o, is_in_delayslot_o, flush_o, redirect_valid_o} !== 131'h0) begin
            tests_failed++;
            $display("FAIL reset_in_redir: exc=%h pc=%h bad=%h npc=%h ds=%b fl=%b rv=%b required all 0",
                     excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o, is_in_delayslot_o, flush_o, redirect_valid_o);
        end
    endtask

    task automatic test_random();
        bit          m_redir = 1'b0;
        logic [31:0] m_pc    = 32'h0;
        logic [31:0] code;
        int          errs    = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            mem_valid_i        = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       mem_except_i = 9'h0;
                1:       mem_except_i = 9'h1 << $urandom_range(0, 8);
                2:       mem_except_i = 9'($urandom);
                default: mem_except_i = 9'h0;
            endcase
            mem_pc_i           = $urandom;
            mem_addr_i         = $urandom;
            mem_in_delayslot_i = 1'($urandom);
            cp0_status_i       = $urandom;
            if ($urandom_range(0, 1) == 0) cp0_status_i[1:0] = 2'b01;
            cp0_cause_i        = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF_00FF);
            cp0_epc_i          = $urandom;
            cp0_ebase_i        = $urandom;
            wb_cp0_we_i        = 1'($urandom);
            wb_cp0_waddr_i     = 5'(12 + $urandom_range(0, 4));
            wb_cp0_data_i      = $urandom;
            redirect_ready_i   = ($urandom_range(0, 2) != 0);
            #1;
            code = m_code();
            tests_run++;
            if (m_redir) begin
                if (excepttype_o !== 32'h0 || flush_o !== 1'b1 || redirect_valid_o !== 1'b1 || new_pc_o !== m_pc) begin
                    tests_failed++; errs++;
                    if (errs < 10) $display("FAIL rand_redir[%0d]: exc=%h fl=%b rv=%b npc=%h required 0/1/1/%h",
                                            n, excepttype_o, flush_o, redirect_valid_o, new_pc_o, m_pc);
                end
                if (redirect_ready_i) m_redir = 1'b0;
            end else begin
                if (excepttype_o !== code || flush_o !== (code != 32'h0) || redirect_valid_o !== 1'b0 ||
                    current_inst_addr_o !== mem_pc_i || is_in_delayslot_o !== mem_in_delayslot_i ||
                    badvaddr_o !== ((code == 32'h10) ? mem_pc_i : (code == 32'h11 || code == 32'h12) ? mem_addr_i : 32'h0)) begin
                    tests_failed++; errs++;
                    if (errs < 10) $display("FAIL rand_idle[%0d]: exc=%h fl=%b rv=%b bad=%h required exc=%h",
                                            n, excepttype_o, flush_o, redirect_valid_o, badvaddr_o, code);
                end
                if (code != 32'h0) begin m_redir = 1'b1; m_pc = m_target(code); end
            end
        end
        @(negedge clk);
        clear_inputs();
        redirect_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 redirect_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_delayslot_load();
        test_eret_forward();
        test_fetch_stall();
        test_priority();
        test_reset_in_redir();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
